// File: rtl/board_eval_if.sv
// Avalon-MM signal bundle used for both the control slave and the SDRAM master of board_eval.
interface board_eval_if #(parameter int ADDR_W = 32);
  logic              waitrequest;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic              write;
  logic [31:0]       writedata;

  modport master (output address, read, write, writedata,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, read, write, writedata,
                  output waitrequest, readdata);
endinterface

// File: rtl/board_eval.sv
// Board evaluator: DMA-reads N 64-square boards and writes one signed material score per board.
// Optional macro PAWN_ADVANCE_EN adds a per-pawn rank bonus to the score.
module board_eval #(
  parameter int MAX_BOARDS = 12,
  parameter int PAWN_VAL   = 100,
  parameter int KNIGHT_VAL = 320,
  parameter int BISHOP_VAL = 330,
  parameter int ROOK_VAL   = 500,
  parameter int QUEEN_VAL  = 900,
  parameter int KING_VAL   = 20000
) (
  input  logic         clk,
  input  logic         rst,
  board_eval_if.slave  avs,
  board_eval_if.master avm
);
  // state    | meaning
  // IDLE     | waiting for start, configuration writable
  // RD_REQ   | master read of word k of board b, held until accepted
  // RD_WAIT  | one read outstanding, accumulate on readdatavalid
  // WR_SCORE | master write of board b score, held until accepted
  // DONE     | job finished, waiting for the blocking R0 read

  localparam int CW = $clog2(MAX_BOARDS + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_SCORE, DONE} state_t;
  state_t state_q, state_d;

  logic [31:0]   src_base, dst_base, acc;
  logic [CW-1:0] count, board_idx, done_cnt;
  logic [3:0]    word_idx;
  logic          err;

  logic          start_now, cfg_wr, r0_rd, rd_beat, wr_ack, last_board;
  logic          slv_wait, mst_read, mst_write;
  logic [31:0]   slv_rdata, word_sum, weight;
  logic          word_err;
  logic [7:0]    code, mag;
`ifdef PAWN_ADVANCE_EN
  logic [2:0]    bonus;
`endif

  function automatic logic [31:0] piece_weight(input logic [7:0] m);
    if (m == 8'd0)       return 32'd0;
    else if (m <= 8'd8)  return 32'(PAWN_VAL);
    else if (m <= 8'd18) return 32'(ROOK_VAL);
    else if (m <= 8'd28) return 32'(KNIGHT_VAL);
    else if (m <= 8'd38) return 32'(BISHOP_VAL);
    else if (m <= 8'd47) return 32'(QUEEN_VAL);
    else if (m == 8'd48) return 32'(KING_VAL);
    else                 return 32'd0;
  endfunction

  assign start_now  = avs.write && (avs.address == 4'd0) && (state_q == IDLE);
  assign cfg_wr     = avs.write && (state_q == IDLE);
  assign r0_rd      = avs.read && (avs.address == 4'd0);
  assign rd_beat    = (state_q == RD_WAIT) && avm.readdatavalid;
  assign wr_ack     = (state_q == WR_SCORE) && !avm.waitrequest;
  assign last_board = (CW'(board_idx + 1'b1) == count);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    slv_wait  = 1'b0;
    mst_read  = 1'b0;
    mst_write = 1'b0;
    case (state_q)
      IDLE: begin
        // a start in the same cycle as an R0 read wins, so that read must block
        if (start_now) begin
          state_d  = (count == '0) ? DONE : RD_REQ;
          slv_wait = r0_rd;
        end
      end
      RD_REQ: begin
        mst_read = 1'b1;
        slv_wait = r0_rd;
        if (!avm.waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        slv_wait = r0_rd;
        if (avm.readdatavalid) state_d = (word_idx == 4'd15) ? WR_SCORE : RD_REQ;
      end
      WR_SCORE: begin
        mst_write = 1'b1;
        slv_wait  = r0_rd;
        if (!avm.waitrequest) state_d = last_board ? DONE : RD_REQ;
      end
      DONE: begin
        if (r0_rd) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_sum = '0;
    word_err = 1'b0;
    code     = '0;
    mag      = '0;
    weight   = '0;
`ifdef PAWN_ADVANCE_EN
    bonus    = '0;
`endif
    for (int j = 0; j < 4; j++) begin
      code   = avm.readdata[8*j +: 8];
      mag    = code[7] ? 8'(~code + 8'd1) : code;
      weight = piece_weight(mag);
`ifdef PAWN_ADVANCE_EN
      // rank of every square in word k is k>>1
      if (mag != 8'd0 && mag <= 8'd8) begin
        bonus  = code[7] ? 3'(3'd7 - word_idx[3:1]) : word_idx[3:1];
        weight = weight + 32'(bonus) * 32'd10;
      end
`endif
      word_sum = code[7] ? (word_sum - weight) : (word_sum + weight);
      if (mag > 8'd48) word_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_base  <= '0;
      dst_base  <= '0;
      count     <= '0;
      board_idx <= '0;
      word_idx  <= '0;
      done_cnt  <= '0;
      acc       <= '0;
      err       <= 1'b0;
    end else begin
      if (cfg_wr) begin
        case (avs.address)
          4'd1: src_base <= avs.writedata;
          4'd2: count    <= (avs.writedata > 32'(MAX_BOARDS)) ? CW'(MAX_BOARDS) : CW'(avs.writedata);
          4'd3: dst_base <= avs.writedata;
          default: ;
        endcase
      end
      if (start_now) begin
        board_idx <= '0;
        word_idx  <= '0;
        done_cnt  <= '0;
        acc       <= '0;
        err       <= 1'b0;
      end
      if (rd_beat) begin
        acc      <= acc + word_sum;
        err      <= err | word_err;
        word_idx <= word_idx + 4'd1;
      end
      if (wr_ack) begin
        acc       <= '0;
        board_idx <= board_idx + 1'b1;
        if (last_board) done_cnt <= count;
      end
    end
  end

  always_comb begin
    slv_rdata = '0;
    if (avs.read && !slv_wait) begin
      case (avs.address)
        4'd0:    slv_rdata = 32'(done_cnt);
        4'd4:    slv_rdata = {31'd0, err};
        default: slv_rdata = '0;
      endcase
    end
  end

  assign avs.waitrequest = slv_wait;
  assign avs.readdata    = slv_rdata;
  assign avm.read        = mst_read;
  assign avm.write       = mst_write;
  assign avm.address     = mst_read  ? (src_base + 32'(board_idx) * 32'd64 + 32'(word_idx) * 32'd4) :
                           mst_write ? (dst_base + 32'(board_idx) * 32'd4) : 32'd0;
  assign avm.writedata   = mst_write ? acc : 32'd0;
endmodule
